// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame admission, credit gating and output annotation around a 64-point SDF FFT
module fft_frame_sequencer #(
  parameter int N       = 64,
  parameter int LOG2N   = 6,
  parameter int WIDTH   = 16,
  parameter int CREDITS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data_r,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             fft_en,
  output logic [WIDTH-1:0] fft_r,
  output logic [WIDTH-1:0] fft_i,
  input  logic             fft_oen,
  input  logic [WIDTH-1:0] fft_or,
  input  logic [WIDTH-1:0] fft_oi,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data_r,
  output logic [WIDTH-1:0] m_data_i,
  output logic [LOG2N-1:0] m_bin,
  output logic             m_first,
  output logic             m_last,
  output logic [7:0]       m_frame,
  input  logic             credit_ret,
  output logic [3:0]       credits,
  output logic             busy,
  output logic [1:0]       err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [LOG2N-1:0] in_idx, in_idx_nx;
  logic [LOG2N-1:0] out_idx;
  logic [LOG2N-1:0] out_idx_rev;
  logic [7:0]       inflight;
  logic [3:0]       credit_cnt;
  logic             accept;
  logic             start;
  logic             in_last;
  logic             out_last;
  logic             out_dec;

  // Outside a frame, a new start needs both permission and a free downstream slot.
  assign s_ready  = (state == RUN) || (enable && (credit_cnt != 4'd0));
  assign accept   = s_valid && s_ready;
  assign start    = accept && (state == IDLE);
  assign in_last  = accept && ((state == RUN) ? (in_idx == LOG2N'(N - 1)) : (N == 1));
  assign out_last = fft_oen && (out_idx == LOG2N'(N - 1));
  // An orphan last sample must not underflow the in-flight count.
  assign out_dec  = out_last && (inflight != 8'd0);
  assign credits  = credit_cnt;
  assign busy     = (state == RUN) || (inflight != 8'd0);

  genvar b;
  for (b = 0; b < LOG2N; b++) begin : g_rev
    assign out_idx_rev[b] = out_idx[LOG2N-1-b];
  end

  // Next-state and input index: a frame runs until sample N-1 is accepted, gaps allowed.
  always_comb begin
    state_nx  = state;
    in_idx_nx = in_idx;
    if (accept) begin
      if (in_last) begin
        state_nx  = IDLE;
        in_idx_nx = '0;
      end else begin
        state_nx  = RUN;
        in_idx_nx = in_idx + LOG2N'(1);
      end
    end
  end

  // State register and input sample index.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      in_idx <= '0;
    end else begin
      state  <= state_nx;
      in_idx <= in_idx_nx;
    end
  end

  // Credit and in-flight bookkeeping, plus sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit_cnt <= 4'(CREDITS);
      inflight   <= 8'd0;
      err        <= 2'b00;
    end else begin
      if (credit_ret && !start) begin
        if (credit_cnt == 4'(CREDITS)) err[1] <= 1'b1;
        else                           credit_cnt <= credit_cnt + 4'd1;
      end else if (start && !credit_ret) begin
        credit_cnt <= credit_cnt - 4'd1;
      end
      case ({start, out_dec})
        2'b10:   inflight <= inflight + 8'd1;
        2'b01:   inflight <= inflight - 8'd1;
        default: inflight <= inflight;
      endcase
      if (fft_oen && (inflight == 8'd0)) err[0] <= 1'b1;
    end
  end

  // FFT input register: strobe follows accept, data holds between accepts.
  always_ff @(posedge clock) begin
    if (reset) begin
      fft_en <= 1'b0;
      fft_r  <= '0;
      fft_i  <= '0;
    end else begin
      fft_en <= accept;
      if (accept) begin
        fft_r <= s_data_r;
        fft_i <= s_data_i;
      end
    end
  end

  // Output register: annotate each FFT output with its bin, frame markers and frame number.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_data_r <= '0;
      m_data_i <= '0;
      m_bin    <= '0;
      m_first  <= 1'b0;
      m_last   <= 1'b0;
      m_frame  <= 8'd0;
      out_idx  <= '0;
    end else begin
      m_valid <= fft_oen;
      if (fft_oen) begin
        m_data_r <= fft_or;
        m_data_i <= fft_oi;
        m_bin    <= out_idx_rev;
        m_first  <= (out_idx == '0);
        m_last   <= out_last;
        out_idx  <= out_last ? '0 : out_idx + LOG2N'(1);
      end
      if (m_valid && m_last) m_frame <= m_frame + 8'd1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - scoreboard bench for fft_frame_sequencer
module tb_fft_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data_r;
  logic [15:0] s_data_i;
  logic        fft_en;
  logic [15:0] fft_r;
  logic [15:0] fft_i;
  logic        fft_oen;
  logic [15:0] fft_or;
  logic [15:0] fft_oi;
  logic        m_valid;
  logic [15:0] m_data_r;
  logic [15:0] m_data_i;
  logic [5:0]  m_bin;
  logic        m_first;
  logic        m_last;
  logic [7:0]  m_frame;
  logic        credit_ret;
  logic [3:0]  credits;
  logic        busy;
  logic [1:0]  err;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] i;
  } in_t;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] i;
    logic [5:0]  bin;
    logic        first;
    logic        last;
    logic [7:0]  frame;
  } out_t;

  in_t  in_q[$];
  out_t out_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          fft_cnt = 0;
  logic [15:0] next_val = 16'd0;
  logic [7:0]  exp_frame = 8'd0;

  fft_frame_sequencer #(.N(64), .LOG2N(6), .WIDTH(16), .CREDITS(2)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_r(s_data_r), .s_data_i(s_data_i),
    .fft_en(fft_en), .fft_r(fft_r), .fft_i(fft_i),
    .fft_oen(fft_oen), .fft_or(fft_or), .fft_oi(fft_oi),
    .m_valid(m_valid), .m_data_r(m_data_r), .m_data_i(m_data_i), .m_bin(m_bin),
    .m_first(m_first), .m_last(m_last), .m_frame(m_frame),
    .credit_ret(credit_ret), .credits(credits), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int k = 0; k < 6; k++) r[k] = v[5-k];
    return r;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Offer samples (every cycle, or every other cycle when gap=1) until n are accepted.
  task automatic stream(input int n, input bit gap, input int drop_after, output int acc, output int cyc);
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 400) begin
      s_valid  = gap ? ((cyc % 2) == 0) : 1'b1;
      s_data_r = next_val;
      s_data_i = ~next_val;
      #1;
      if (s_valid && s_ready) begin
        in_q.push_back('{r: next_val, i: ~next_val});
        next_val = next_val + 16'd1;
        acc++;
      end
      tick();
      cyc++;
      if (acc == drop_after) enable = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  // Stub FFT core: play out one 64-beat output frame.
  task automatic emit_frame(input logic [15:0] base);
    for (int k = 0; k < 64; k++) begin
      fft_oen = 1'b1;
      fft_or  = base + 16'(k);
      fft_oi  = 16'h8000 ^ 16'(k);
      out_q.push_back('{r: base + 16'(k), i: 16'h8000 ^ 16'(k), bin: rev6(6'(k)),
                        first: (k == 0), last: (k == 63), frame: exp_frame});
      tick();
    end
    fft_oen   = 1'b0;
    exp_frame = exp_frame + 8'd1;
  endtask

  task automatic pulse_credit;
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
  endtask

  // Monitor: compare every presented FFT input beat and every annotated output beat.
  always @(negedge clock) begin
    if (!reset) begin
      if (fft_en) begin
        fft_cnt++;
        if (in_q.size() == 0) begin
          check("fft_in_unexpected", 32'(fft_r), 32'hFFFF_FFFF);
        end else begin
          in_t e;
          e = in_q.pop_front();
          check("fft_r", 32'(fft_r), 32'(e.r));
          check("fft_i", 32'(fft_i), 32'(e.i));
        end
      end
      if (m_valid) begin
        if (out_q.size() == 0) begin
          check("m_unexpected", 32'(m_data_r), 32'hFFFF_FFFF);
        end else begin
          out_t o;
          o = out_q.pop_front();
          check("m_data_r", 32'(m_data_r), 32'(o.r));
          check("m_data_i", 32'(m_data_i), 32'(o.i));
          check("m_bin",    32'(m_bin),    32'(o.bin));
          check("m_first",  32'(m_first),  32'(o.first));
          check("m_last",   32'(m_last),   32'(o.last));
          check("m_frame",  32'(m_frame),  32'(o.frame));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc, f0;
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data_r = '0; s_data_i = '0;
    fft_oen = 1'b0; fft_or = '0; fft_oi = '0; credit_ret = 1'b0;

    // 1. reset
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_credits", 32'(credits), 32'd2);
    check("rst_fft_en",  32'(fft_en),  32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_m_frame", 32'(m_frame), 32'd0);
    check("rst_m_bin",   32'(m_bin),   32'd0);
    tick();

    // 2. single frame in and out
    enable = 1'b1;
    f0 = fft_cnt;
    stream(64, 1'b0, -1, acc, cyc);
    check("t2_acc", 32'(acc), 32'd64);
    check("t2_contig", 32'(cyc), 32'd64);
    check("t2_credits", 32'(credits), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    tick();
    check("t2_fft_cnt", 32'(fft_cnt - f0), 32'd64);
    emit_frame(16'h1000);
    tick(); tick();
    check("t2_m_frame", 32'(m_frame), 32'd1);
    check("t2_busy_after", 32'(busy), 32'd0);
    pulse_credit();
    check("t2_credit_back", 32'(credits), 32'd2);

    // 3. credit exhaustion
    stream(128, 1'b0, -1, acc, cyc);
    check("t3_acc", 32'(acc), 32'd128);
    check("t3_contig", 32'(cyc), 32'd128);
    #1;
    check("t3_s_ready_blocked", 32'(s_ready), 32'd0);
    check("t3_credits0", 32'(credits), 32'd0);
    tick();
    check("t3_still_blocked", 32'(s_ready), 32'd0);
    pulse_credit();
    check("t3_s_ready_back", 32'(s_ready), 32'd1);
    check("t3_credits1", 32'(credits), 32'd1);
    stream(64, 1'b0, -1, acc, cyc);
    check("t3_third_acc", 32'(acc), 32'd64);
    check("t3_credits_end", 32'(credits), 32'd0);
    emit_frame(16'h2000);
    emit_frame(16'h2100);
    emit_frame(16'h2200);
    tick(); tick();
    check("t3_m_frame", 32'(m_frame), 32'd4);
    check("t3_busy", 32'(busy), 32'd0);
    pulse_credit();
    pulse_credit();
    check("t3_credits2", 32'(credits), 32'd2);

    // 4. gaps plus enable drop after sample 10
    f0 = fft_cnt;
    stream(64, 1'b1, 10, acc, cyc);
    check("t4_acc", 32'(acc), 32'd64);
    tick(); tick();
    check("t4_fft_cnt", 32'(fft_cnt - f0), 32'd64);
    check("t4_s_ready", 32'(s_ready), 32'd0);
    check("t4_credits", 32'(credits), 32'd1);
    emit_frame(16'h3000);

    // 5a. credit_ret coinciding with an IDLE start at credits=1
    enable   = 1'b1;
    s_valid  = 1'b1;
    s_data_r = next_val;
    s_data_i = ~next_val;
    credit_ret = 1'b1;
    #1;
    check("t5_start_ready", 32'(s_ready), 32'd1);
    if (s_ready) begin
      in_q.push_back('{r: next_val, i: ~next_val});
      next_val = next_val + 16'd1;
    end
    tick();
    credit_ret = 1'b0;
    s_valid    = 1'b0;
    check("t5_credits_same", 32'(credits), 32'd1);
    check("t5_no_err", 32'(err), 32'd0);
    stream(63, 1'b0, -1, acc, cyc);
    check("t5_acc_a", 32'(acc), 32'd63);

    // 5b. last output beat of frame A coincides with start of frame B
    for (int k = 0; k < 64; k++) begin
      fft_oen = 1'b1;
      fft_or  = 16'h4000 + 16'(k);
      fft_oi  = 16'h8000 ^ 16'(k);
      out_q.push_back('{r: 16'h4000 + 16'(k), i: 16'h8000 ^ 16'(k), bin: rev6(6'(k)),
                        first: (k == 0), last: (k == 63), frame: exp_frame});
      if (k == 63) begin
        s_valid  = 1'b1;
        s_data_r = next_val;
        s_data_i = ~next_val;
        #1;
        check("t5_b_ready", 32'(s_ready), 32'd1);
        if (s_ready) begin
          in_q.push_back('{r: next_val, i: ~next_val});
          next_val = next_val + 16'd1;
        end
      end
      tick();
    end
    fft_oen   = 1'b0;
    s_valid   = 1'b0;
    exp_frame = exp_frame + 8'd1;
    check("t5_b_credits", 32'(credits), 32'd0);
    stream(63, 1'b0, -1, acc, cyc);
    tick();
    check("t5_inflight_kept", 32'(busy), 32'd1);
    emit_frame(16'h5000);
    tick(); tick();
    check("t5_busy_done", 32'(busy), 32'd0);
    check("t5_err_clear", 32'(err), 32'd0);
    check("t5_m_frame", 32'(m_frame), 32'd7);
    pulse_credit();
    pulse_credit();
    check("t5_credits2", 32'(credits), 32'd2);

    // 6. errors
    fft_oen = 1'b1;
    fft_or  = 16'hBEEF;
    fft_oi  = 16'h1234;
    out_q.push_back('{r: 16'hBEEF, i: 16'h1234, bin: 6'd0, first: 1'b1, last: 1'b0, frame: exp_frame});
    tick();
    fft_oen = 1'b0;
    tick();
    check("t6_err_orphan", 32'(err), 32'd1);
    pulse_credit();
    check("t6_err_both", 32'(err), 32'd3);
    check("t6_credits", 32'(credits), 32'd2);
    repeat (3) tick();
    check("t6_err_sticky", 32'(err), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_err_reset", 32'(err), 32'd0);
    check("t6_credits_reset", 32'(credits), 32'd2);
    check("t6_m_frame_reset", 32'(m_frame), 32'd0);
    check("in_q_empty", 32'(in_q.size()), 32'd0);
    check("out_q_empty", 32'(out_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
